// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and helpers for the conv layer scheduler
package conv_pkg;

  localparam int ACC_W_DEF = 32;
  localparam int RES_MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT,
    FIN
  } state_t;

  // Callers sign-extend to RES_MAX_W, so the MSB here is the sign of the narrower sum.
  function automatic logic signed [RES_MAX_W-1:0] relu(input logic signed [RES_MAX_W-1:0] acc);
    return acc[RES_MAX_W-1] ? '0 : acc;
  endfunction

endpackage

// File: rtl/conv_layer_sched_if.sv
// rtl/conv_layer_sched_if.sv - sequencer, engine, memory and output-stream signals of the scheduler
interface conv_layer_sched_if #(
  parameter int MAPSIZE = 32,
  parameter int CH_W    = 4,
  parameter int ACC_W   = 32
);
  localparam int OUT_DIM = MAPSIZE - 4;
  localparam int XY_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  logic              start;
  logic              abort;
  logic [CH_W-1:0]   cfg_in_last;
  logic [CH_W-1:0]   cfg_out_last;
  logic              eng_start;
  logic              eng_done;
  logic [ACC_W-1:0]  eng_result;
  logic [XY_W-1:0]   win_x;
  logic [XY_W-1:0]   win_y;
  logic [CH_W-1:0]   in_ch;
  logic [CH_W-1:0]   out_ch;
  logic [ACC_W-1:0]  bias_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              busy;
  logic              done;

  modport slave (
    input  start, abort, cfg_in_last, cfg_out_last, eng_done, eng_result, bias_data, out_ready,
    output eng_start, win_x, win_y, in_ch, out_ch, out_valid, out_data, busy, done
  );

  modport master (
    output start, abort, cfg_in_last, cfg_out_last, eng_done, eng_result, bias_data, out_ready,
    input  eng_start, win_x, win_y, in_ch, out_ch, out_valid, out_data, busy, done
  );

endinterface

// File: rtl/conv_index_counter.sv
// rtl/conv_index_counter.sv - nested x -> y -> out_ch pixel counter
module conv_index_counter #(
  parameter int OUT_DIM = 28,
  parameter int CH_W    = 4,
  parameter int XY_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_advance,
  input  logic [CH_W-1:0] i_ch_last,
  output logic [XY_W-1:0] o_x,
  output logic [XY_W-1:0] o_y,
  output logic [CH_W-1:0] o_ch,
  output logic            o_last
);

  localparam logic [XY_W-1:0] XY_LAST = XY_W'(OUT_DIM - 1);

  logic [XY_W-1:0] r_x;
  logic [XY_W-1:0] r_y;
  logic [CH_W-1:0] r_ch;
  logic            w_x_last;
  logic            w_y_last;

  assign w_x_last = (r_x == XY_LAST);
  assign w_y_last = (r_y == XY_LAST);
  assign o_last   = w_x_last && w_y_last && (r_ch == i_ch_last);
  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_ch     = r_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_y  <= '0;
      r_ch <= '0;
    end else if (i_clear) begin
      r_x  <= '0;
      r_y  <= '0;
      r_ch <= '0;
    end else if (i_advance) begin
      if (!w_x_last) begin
        r_x <= r_x + 1'b1;
      end else begin
        r_x <= '0;
        if (!w_y_last) begin
          r_y <= r_y + 1'b1;
        end else begin
          r_y  <= '0;
          r_ch <= r_ch + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_layer_sched.sv
// rtl/conv_layer_sched.sv - layer loop nest, engine handshake, bias/ReLU and result stream
module conv_layer_sched
  import conv_pkg::*;
#(
  parameter int MAPSIZE = 32,
  parameter int CH_W    = 4,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int RELU    = 1
) (
  input logic               clk,
  input logic               rst_n,
  conv_layer_sched_if.slave bus
);

  localparam int OUT_DIM = MAPSIZE - 4;
  localparam int XY_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  state_t                   r_state;
  logic [CH_W-1:0]          r_in_last;
  logic [CH_W-1:0]          r_out_last;
  logic [CH_W-1:0]          r_in_ch;
  logic signed [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]         r_out_data;
  logic                     r_eng_start;
  logic                     r_out_valid;
  logic                     r_busy;
  logic                     r_done;

  logic                     w_clear;
  logic                     w_advance;
  logic                     w_last;
  logic [XY_W-1:0]          w_x;
  logic [XY_W-1:0]          w_y;
  logic [CH_W-1:0]          w_out_ch;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [RES_MAX_W-1:0] w_sum_ext;
  logic [ACC_W-1:0]         w_result;

  // The counter holds its final position on the last pixel so the indices stay visible after FIN.
  assign w_clear   = (r_state == IDLE) && bus.start && !bus.abort;
  assign w_advance = (r_state == EMIT) && bus.out_ready && !bus.abort && !w_last;

  conv_index_counter #(
    .OUT_DIM (OUT_DIM),
    .CH_W    (CH_W),
    .XY_W    (XY_W)
  ) u_index (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .i_ch_last (r_out_last),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_ch      (w_out_ch),
    .o_last    (w_last)
  );

  assign w_sum     = r_acc + bus.eng_result + bus.bias_data;
  assign w_sum_ext = RES_MAX_W'(w_sum);
  assign w_result  = (RELU != 0) ? ACC_W'(relu(w_sum_ext)) : w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_last   <= '0;
      r_out_last  <= '0;
      r_in_ch     <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_eng_start <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_eng_start <= 1'b0;
      r_done      <= 1'b0;
      if (bus.abort) begin
        r_state     <= IDLE;
        r_acc       <= '0;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (bus.start) begin
            r_in_last   <= bus.cfg_in_last;
            r_out_last  <= bus.cfg_out_last;
            r_in_ch     <= '0;
            r_acc       <= '0;
            r_eng_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
          ISSUE: r_state <= WAIT;
          WAIT: if (bus.eng_done) begin
            if (r_in_ch < r_in_last) begin
              r_acc       <= r_acc + bus.eng_result;
              r_in_ch     <= r_in_ch + 1'b1;
              r_eng_start <= 1'b1;
              r_state     <= ISSUE;
            end else begin
              r_out_data  <= w_result;
              r_acc       <= '0;
              r_out_valid <= 1'b1;
              r_state     <= EMIT;
            end
          end
          EMIT: if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ch     <= '0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_eng_start <= 1'b1;
              r_state     <= ISSUE;
            end
          end
          FIN: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.eng_start = r_eng_start;
  assign bus.win_x     = w_x;
  assign bus.win_y     = w_y;
  assign bus.in_ch     = r_in_ch;
  assign bus.out_ch    = w_out_ch;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
Multi-channel layer scheduler for the shared 5x5 window engine (`conv`).
- Owns the loop nest: out_ch → y → x → in_ch.
- Drives window/weight addressing and the engine start/done handshake.
- Accumulates partial sums across input channels, adds a per-output-channel bias, applies optional ReLU.
- Streams one result per output pixel with valid/ready back-pressure.
- Sits between the layer sequencer (cfg/start) and the feature/weight/bias memories plus the output buffer.

Parameters:
- MAPSIZE, 32, input feature map edge. OUT_DIM = MAPSIZE-4 outputs per row/col. XY_W = $clog2(OUT_DIM).
- CH_W, 4, channel index width (max 2^CH_W channels per dimension).
- ACC_W, 32, accumulator/result width (signed).
- RELU, 1, 1 = clamp negative results to 0 on output; 0 = pass-through.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin layer; sampled only in IDLE.
- abort  in  1  synchronous abort; return to IDLE.
- cfg_in_last  in  CH_W  input channel count minus 1.
- cfg_out_last  in  CH_W  output channel count minus 1.
- eng_start  out  1  one-cycle start pulse to the window engine.
- eng_done  in  1  engine result valid.
- eng_result  in  ACC_W  engine 5x5 dot product, signed.
- win_x, win_y  out  XY_W each  window top-left / output pixel coordinate.
- in_ch, out_ch  out  CH_W each  current channel indices (feature, weight and bias addressing).
- bias_data  in  ACC_W  bias for out_ch, combinational from external ROM, signed.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  ACC_W  biased (ReLU'd) pixel result.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all indices, acc and out_data = 0.
  - eng_start, out_valid, busy, done = 0.
  - Deassertion takes effect on the next clk edge.
- State enum: IDLE, ISSUE, WAIT, EMIT, FIN.
- IDLE:
  - On start=1: latch cfg_in_last/cfg_out_last; zero all indices and acc; go to ISSUE.
  - start while busy is ignored.
- ISSUE: eng_start=1 for exactly this cycle; then go to WAIT. eng_done is ignored in ISSUE.
- WAIT: on eng_done=1:
  - in_ch < in_last: acc += eng_result; in_ch++; go to ISSUE.
  - in_ch == in_last: out_data <= acc + eng_result + bias_data (ReLU applied if RELU=1); acc <= 0; go to EMIT.
- EMIT:
  - out_valid=1; out_data, win_x/y and out_ch are held stable until out_ready.
  - On out_ready: in_ch <= 0, then advance x; wrap x at OUT_DIM-1 → advance y; wrap y → advance out_ch.
  - If x, y and out_ch are all last: go to FIN, otherwise to ISSUE.
- FIN: done=1 for one cycle; go to IDLE. Indices keep their final values until the next start.
- Arithmetic:
  - Two's complement, ACC_W bits; overflow wraps with no saturation.
  - ReLU tests the MSB of the final sum.
- Latency:
  - If the engine asserts done L≥1 cycles after eng_start, each in_ch costs L+1 cycles.
  - Each pixel costs (in_last+1)(L+1) cycles plus EMIT cycles (≥1).
  - Back-to-back accepts (out_ready held 1) add exactly one cycle per pixel.
- Boundary conditions:
  - cfg_in_last=0: single pass per pixel.
  - MAPSIZE=5: OUT_DIM=1, one pixel per channel.
  - abort in any state: next cycle IDLE, outputs deasserted, acc cleared, no done. Abort wins over start/eng_done/out_ready in the same cycle.
  - A stray eng_done in IDLE, EMIT or FIN is ignored.
  - rst_n low mid-layer: immediate return to reset values.

Decomposition:
- conv_pkg holds:
  - the state_t enum;
  - the ACC_W default;
  - the helper function relu(acc).
- Sub-module conv_index_counter: nested x/y/out_ch counter with an advance input and a last output; parameterised by OUT_DIM and CH_W.

Test Plan:
- MAPSIZE=8, in_last=0, out_last=0, engine L=1 returns x+4y, bias=0 → 16 outputs in raster order, values 0..15, done pulses once after the 16th accept.
- in_last=2, engine returns 10 per call, bias=5 → every out_data=35; exactly 3 eng_start pulses per pixel.
- Engine returns -100, bias=20, RELU=1 → out_data=0. Same stimulus with RELU=0 → out_data=-80 (0xFFFFFFB0).
- out_ready held 0 for 7 cycles on pixel (1,0) → out_valid stays 1 with out_data stable; no eng_start until accept; next pixel is (2,0).
- abort asserted in WAIT of pixel (2,3) → IDLE next cycle, busy=0, no done. New start restarts at (0,0,ch0) with acc=0.
- Engine L=4 and rst_n pulsed low mid-EMIT → all outputs 0 asynchronously. Stray eng_done in IDLE → no state change.
